// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the instruction-memory boot loader.
//                It holds the loader FSM state enumeration, the byte and
//                instruction widths, and the default frame start byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] DEFAULT_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Receives a framed program image over a byte valid/ready
//                stream. Frame layout: MAGIC, N, 2N payload bytes (high byte
//                first), then the XOR of all payload bytes. Each byte pair is
//                written to instruction memory as one 16-bit word, starting at
//                address 0. The CPU is held in reset until the image has been
//                loaded and the checksum matches.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_data/valid/ready - byte stream handshake
//                imem_we/addr/wdata - instruction memory write port
//                cpu_rst           - CPU reset, released on success
//                done / error      - sticky load status
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import cpu_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter logic [BYTE_W-1:0] MAGIC  = DEFAULT_MAGIC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               error
);

    localparam logic [2:0] c_ST_IDLE = IDLE;
    localparam logic [2:0] c_ST_LEN  = LEN;
    localparam logic [2:0] c_ST_HI   = HI;
    localparam logic [2:0] c_ST_LO   = LO;
    localparam logic [2:0] c_ST_CHK  = CHK;
    localparam logic [2:0] c_ST_DONE = DONE;
    localparam logic [2:0] c_ST_ERR  = ERR;

    // Largest word count the memory can hold; the 8-bit length byte caps it
    // at 255 regardless of how wide the address is.
    localparam int c_MAX_WORDS = (ADDR_W >= 8) ? 255 : (1 << ADDR_W);

    logic [2:0]         r_state;
    logic [BYTE_W-1:0]  r_len;
    logic [BYTE_W-1:0]  r_count;
    logic [BYTE_W-1:0]  r_chk;
    logic [BYTE_W-1:0]  r_hi;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_error;

    logic               w_ready;
    logic               w_accept;
    logic [BYTE_W-1:0]  w_count_next;

    // Ready is a pure decode of the state so a byte offered in the first
    // cycle after entering a state is taken without a bubble.
    always_comb begin
        w_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE, c_ST_LEN, c_ST_HI, c_ST_LO, c_ST_CHK: w_ready = 1'b1;
                default:                                         w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept     = in_valid && w_ready;
    assign w_count_next = r_count + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_chk     <= '0;
            r_hi      <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per assembled word.
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (in_data == MAGIC) begin
                            r_state <= c_ST_LEN;
                        end
                    end
                    c_ST_LEN: begin
                        if ((in_data == '0) || (int'(in_data) > c_MAX_WORDS)) begin
                            r_state <= c_ST_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_len   <= in_data;
                            r_count <= '0;
                            r_chk   <= '0;
                            r_state <= c_ST_HI;
                        end
                    end
                    c_ST_HI: begin
                        r_hi    <= in_data;
                        r_chk   <= r_chk ^ in_data;
                        r_state <= c_ST_LO;
                    end
                    c_ST_LO: begin
                        r_chk   <= r_chk ^ in_data;
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_W'(r_count);
                        r_wdata <= {r_hi, in_data};
                        r_count <= w_count_next;
                        r_state <= (w_count_next == r_len) ? c_ST_CHK : c_ST_HI;
                    end
                    c_ST_CHK: begin
                        if (in_data == r_chk) begin
                            r_state   <= c_ST_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= c_ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERR never accept bytes; held until reset.
                    end
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign error      = r_error;

endmodule : imem_boot_loader
`default_nettype wire
